// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state codes,
// requester identifiers, slot record and the round-robin arbitration helper.
package uart_tx_scheduler_pkg;

    localparam logic [1:0] INICIAL     = 2'd0;
    localparam logic [1:0] PREPARACAO  = 2'd1;
    localparam logic [1:0] TRANSMISSAO = 2'd2;
    localparam logic [1:0] FINAL       = 2'd3;

    typedef logic req_id_t;
    localparam req_id_t REQ_A = 1'b0;
    localparam req_id_t REQ_B = 1'b1;

    typedef struct packed {
        logic       pend;
        logic [7:0] dado;
    } slot_t;

    // A lone pending requester always wins; a tie goes to the priority pointer.
    function automatic req_id_t arbitra(input logic pend_a, input logic pend_b,
                                        input req_id_t prioridade);
        if (pend_a && !pend_b)
            return REQ_A;
        else if (pend_b && !pend_a)
            return REQ_B;
        else
            return prioridade;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_baud_tick.sv
// Bit-period pacer: mod-CICLOS_BIT counter with synchronous clear; tick is
// high for the last cycle of each bit period while counting.
module uart_baud_tick #(
    parameter int CICLOS_BIT = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    output logic tick
);

    localparam int              CW     = (CICLOS_BIT > 1) ? $clog2(CICLOS_BIT) : 1;
    localparam logic [CW-1:0]   ULTIMO = CW'(CICLOS_BIT - 1);

    logic [CW-1:0] contagem;

    always_ff @(posedge clock) begin
        if (reset || limpa)
            contagem <= '0;
        else if (contagem == ULTIMO)
            contagem <= '0;
        else
            contagem <= contagem + CW'(1);
    end

    assign tick = (contagem == ULTIMO) && !limpa;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Transmit control unit sharing one 12-bit-frame UART datapath between
// requesters A and B. Define UART_TX_SCHEDULER_DEBUG_EN to expose db_estado.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int CICLOS_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida_a,
    input  logic [7:0] dados_a,
    output logic       ocupado_a,
    output logic       pronto_a,
    input  logic       partida_b,
    input  logic [7:0] dados_b,
    output logic       ocupado_b,
    output logic       pronto_b,
    input  logic       fim,
    output logic       zera,
    output logic       conta,
    output logic       carrega,
    output logic       desloca,
    output logic [7:0] dados_ascii,
`ifdef UART_TX_SCHEDULER_DEBUG_EN
    output logic       ativo,
    output logic [2:0] db_estado
`else
    output logic       ativo
`endif
);

    logic [1:0] estado;
    logic [1:0] estado_prox;
    req_id_t    dono;
    req_id_t    prioridade;
    req_id_t    vencedor;
    slot_t      slot_a;
    slot_t      slot_b;
    logic       esvazia_a;
    logic       esvazia_b;
    logic       limpa_baud;
    logic       tick;

    uart_baud_tick #(
        .CICLOS_BIT(CICLOS_BIT)
    ) u_baud (
        .clock (clock),
        .reset (reset),
        .limpa (limpa_baud),
        .tick  (tick)
    );

    // Baud counter only runs during TRANSMISSAO, so each frame starts at count 0.
    assign limpa_baud = (estado != TRANSMISSAO);
    assign vencedor   = arbitra(slot_a.pend, slot_b.pend, prioridade);

    always_comb begin
        // NOTE: default first so every path assigns estado_prox and no latch is inferred.
        estado_prox = estado;
        case (estado)
            INICIAL:     if (slot_a.pend || slot_b.pend) estado_prox = PREPARACAO;
            PREPARACAO:  estado_prox = TRANSMISSAO;
            TRANSMISSAO: if (fim) estado_prox = FINAL;
            FINAL:       estado_prox = INICIAL;
            default:     estado_prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking throughout so every register updates from pre-edge values.
        if (reset) begin
            estado      <= INICIAL;
            dono        <= REQ_A;
            prioridade  <= REQ_A;
            dados_ascii <= 8'h00;
        end else begin
            estado <= estado_prox;
            if (estado == INICIAL)
                dono <= vencedor;
            if (estado == PREPARACAO)
                dados_ascii <= (dono == REQ_A) ? slot_a.dado : slot_b.dado;
            if (estado == FINAL)
                prioridade <= ~dono;
        end
    end

    // The owner's slot empties at PREPARACAO; a strobe that same cycle still sees ocupado=1.
    assign esvazia_a = (estado == PREPARACAO) && (dono == REQ_A);
    assign esvazia_b = (estado == PREPARACAO) && (dono == REQ_B);

    always_ff @(posedge clock) begin
        // NOTE: only the pend flags are reset; slot data is don't-care until pend qualifies it.
        if (reset) begin
            slot_a.pend <= 1'b0;
            slot_b.pend <= 1'b0;
        end else begin
            if (esvazia_a)
                slot_a.pend <= 1'b0;
            else if (partida_a && !slot_a.pend)
                slot_a <= '{pend: 1'b1, dado: dados_a};

            if (esvazia_b)
                slot_b.pend <= 1'b0;
            else if (partida_b && !slot_b.pend)
                slot_b <= '{pend: 1'b1, dado: dados_b};
        end
    end

    assign ocupado_a = slot_a.pend;
    assign ocupado_b = slot_b.pend;

    assign zera     = (estado == PREPARACAO);
    assign carrega  = (estado == PREPARACAO);
    // Once fim is seen the frame is complete; suppress any coincident tick.
    assign desloca  = (estado == TRANSMISSAO) && tick && !fim;
    assign conta    = desloca;
    assign ativo    = (estado == PREPARACAO) || (estado == TRANSMISSAO);
    assign pronto_a = (estado == FINAL) && (dono == REQ_A);
    assign pronto_b = (estado == FINAL) && (dono == REQ_B);

`ifdef UART_TX_SCHEDULER_DEBUG_EN
    assign db_estado = {1'b0, estado};
`endif

endmodule
